// File: rtl/sc_stream_to_binary_pkg.sv
// rtl/sc_stream_to_binary_pkg.sv - shared state encoding and sizing helper for the stream-to-binary converter
//   Contents: sc_state_e (SC_IDLE/SC_ACCUM/SC_HOLD, 2-bit), clogb2() ceiling-log2 helper.
package sc_stream_to_binary_pkg;

    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_ACCUM = 2'd1,
        SC_HOLD  = 2'd2
    } sc_state_e;

    // Ceiling log2; clogb2(1<<n) == n, so it also sizes a counter that wraps every 2^n.
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_stream_to_binary_if.sv
// rtl/sc_stream_to_binary_if.sv - sample-in / results-out bus of the stream-to-binary converter
//   inputStreams/inputValid : one bit per stochastic stream, qualified by inputValid
//   results/resultValid/resultReady : packed counts (stream k at [k*COUNT_WIDTH +: COUNT_WIDTH]) with handshake
//   master = producer of samples and consumer of results; slave = the converter
interface sc_stream_to_binary_if #(
    parameter int NUM_STREAMS = 16,
    parameter int COUNT_WIDTH = 9
);
    logic [NUM_STREAMS-1:0]             inputStreams;
    logic                               inputValid;
    logic [NUM_STREAMS*COUNT_WIDTH-1:0] results;
    logic                               resultValid;
    logic                               resultReady;

    modport master (
        output inputStreams, inputValid, resultReady,
        input  results, resultValid
    );

    modport slave (
        input  inputStreams, inputValid, resultReady,
        output results, resultValid
    );
endinterface

// File: rtl/sc_bit_counter.sv
// rtl/sc_bit_counter.sv - per-stream ones counter
//   clk, rst : clock, asynchronous active-high reset
//   clear_i  : zero the count (wins over en_i)
//   en_i     : add bit_i this cycle
//   bit_i    : stream sample
//   count_o  : running count of ones
module sc_bit_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, bit_i};
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/sc_stream_to_binary.sv
// rtl/sc_stream_to_binary.sv - counts ones per stochastic stream over 2^LENGTH_LOG2 valid samples
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle pulse opening a window (from IDLE, or from HOLD together with resultReady)
//   busy     : high in ACCUM or HOLD
//   bus      : slave side of sc_stream_to_binary_if (samples in, packed counts out)
module sc_stream_to_binary
    import sc_stream_to_binary_pkg::*;
#(
    parameter int NUM_STREAMS = 16,
    parameter int LENGTH_LOG2 = 8,
    parameter int COUNT_WIDTH = LENGTH_LOG2 + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    sc_stream_to_binary_if.slave bus
);
    localparam int SAMPLE_BITS = clogb2(1 << LENGTH_LOG2);

    sc_state_e                          state_q;
    logic [SAMPLE_BITS-1:0]             sample_cnt_q;
    logic [NUM_STREAMS*COUNT_WIDTH-1:0] results_q;
    logic                               result_valid_q;
    logic                               busy_q;

    logic                               clear_w;
    logic                               en_w;
    logic [NUM_STREAMS*COUNT_WIDTH-1:0] counts_w;
    // Counts including the sample on the bus this cycle, so the result register
    // captures the final sample on the same edge that closes the window.
    logic [NUM_STREAMS*COUNT_WIDTH-1:0] counts_d;

    assign clear_w = start && ((state_q == SC_IDLE) ||
                               (state_q == SC_HOLD && result_valid_q && bus.resultReady));
    assign en_w    = (state_q == SC_ACCUM) && bus.inputValid;

    for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_cnt
        sc_bit_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clear_i (clear_w),
            .en_i    (en_w),
            .bit_i   (bus.inputStreams[k]),
            .count_o (counts_w[k*COUNT_WIDTH +: COUNT_WIDTH])
        );
        assign counts_d[k*COUNT_WIDTH +: COUNT_WIDTH] =
            counts_w[k*COUNT_WIDTH +: COUNT_WIDTH] + {{(COUNT_WIDTH-1){1'b0}}, bus.inputStreams[k]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SC_IDLE;
            sample_cnt_q   <= '0;
            results_q      <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                SC_IDLE: begin
                    if (start) begin
                        state_q      <= SC_ACCUM;
                        sample_cnt_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                SC_ACCUM: begin
                    if (bus.inputValid) begin
                        // Wraps to zero on the final sample, ready for the next window.
                        sample_cnt_q <= sample_cnt_q + SAMPLE_BITS'(1);
                        if (sample_cnt_q == '1) begin
                            results_q      <= counts_d;
                            result_valid_q <= 1'b1;
                            state_q        <= SC_HOLD;
                        end
                    end
                end
                SC_HOLD: begin
                    if (bus.resultReady && result_valid_q) begin
                        result_valid_q <= 1'b0;
                        if (start) begin
                            state_q      <= SC_ACCUM;
                            sample_cnt_q <= '0;
                        end else begin
                            state_q <= SC_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q        <= SC_IDLE;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign bus.results     = results_q;
    assign bus.resultValid = result_valid_q;
endmodule
